// File: rtl/nios_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// nios_debug_ocimem_ctrl
//
// Debug-memory access engine for the Nios II on-chip debug module. Executes
// JTAG word reads/writes (decoded from jdo and the take_*_ocimem_* strobes)
// against a local single-port debug RAM, and shares that RAM with a CPU-side
// slave port. Results are returned to the bridge through MonDReg,
// monitor_ready and monitor_error.
//
// Ports
//   clk, reset_n            system clock, synchronous active-low reset
//   jdo[37:0]               command/data word, valid with any strobe
//   take_action_ocimem_a    load MonAReg from jdo, optional read (jdo[34])
//   take_no_action_ocimem_a increment MonAReg, then read
//   take_action_ocimem_b    load MonDReg from jdo[34:3], write it at MonAReg
//   debugack                JTAG accesses are legal only while high
//   MonDReg[31:0]           monitor data register
//   monitor_ready           high when no JTAG operation is in flight
//   monitor_error           sticky flag for a rejected or dropped strobe
//   cpu_address/read/write/writedata  CPU slave request
//   cpu_readdata[31:0]      CPU read data, one cycle after an accepted read
//   cpu_waitrequest         stalls the CPU while JTAG owns the RAM
// ---------------------------------------------------------------------------
module nios_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              debugack,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_ADDR = 2'd1,
    S_RD_DATA = 2'd2,
    S_WR      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              ready_q;
  logic              error_q, error_d;
  logic [31:0]       jtag_rd_q;
  logic [31:0]       cpu_rd_q;
  logic [31:0]       mem [2**ADDR_W];

  // jdo bits that carry no meaning for this engine
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Strobe qualification: only IDLE with the CPU halted accepts a command
  logic any_strobe;
  logic accept;
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign accept     = (state_q == S_IDLE) && debugack && any_strobe;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic (b > a > no_action priority)
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (take_action_ocimem_b)      state_d = S_WR;
          else if (take_action_ocimem_a) state_d = jdo[34] ? S_RD_ADDR : S_IDLE;
          else                           state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: state_d = S_IDLE;
      S_WR:      state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs: RAM ownership and per-state actions
  // -------------------------------------------------------------------------
  logic jtag_owns;
  logic jtag_rd_en;
  logic jtag_wr_en;
  logic jtag_capture;

  always_comb begin
    jtag_owns    = 1'b0;
    jtag_rd_en   = 1'b0;
    jtag_wr_en   = 1'b0;
    jtag_capture = 1'b0;
    case (state_q)
      S_RD_ADDR: begin
        jtag_owns  = 1'b1;
        jtag_rd_en = 1'b1;
      end
      S_RD_DATA: jtag_capture = 1'b1;
      S_WR: begin
        jtag_owns  = 1'b1;
        jtag_wr_en = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Monitor register next-state
  // -------------------------------------------------------------------------
  always_comb begin
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    error_d = error_q;

    if (accept) begin
      if (take_action_ocimem_b) begin
        mon_d_d = jdo[34:3];
      end else if (take_action_ocimem_a) begin
        mon_a_d = jdo[17+ADDR_W:18];
      end else begin
        mon_a_d = mon_a_q + ADDR_W'(1);
      end
    end

    // Auto-increment after a write so consecutive b strobes stream upward
    if (jtag_wr_en) mon_a_d = mon_a_q + ADDR_W'(1);
    if (jtag_capture) mon_d_d = jtag_rd_q;

    // Rejected (debugack low) or dropped (busy) strobes are both errors
    if (accept)          error_d = 1'b0;
    else if (any_strobe) error_d = 1'b1;
  end

  // -------------------------------------------------------------------------
  // CPU port arbitration and RAM port muxing
  // -------------------------------------------------------------------------
  logic              cpu_rd_acc;
  logic              cpu_wr_acc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  assign cpu_waitrequest = jtag_owns & (cpu_read | cpu_write);
  assign cpu_rd_acc      = cpu_read  & ~jtag_owns;
  assign cpu_wr_acc      = cpu_write & ~jtag_owns;
  assign ram_addr        = jtag_owns ? mon_a_q : cpu_address;
  assign ram_we          = jtag_wr_en | cpu_wr_acc;
  assign ram_wdata       = jtag_wr_en ? mon_d_q : cpu_writedata;

  // -------------------------------------------------------------------------
  // Registers: monitor state, CPU read data
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mon_a_q  <= '0;
      mon_d_q  <= '0;
      ready_q  <= 1'b1;
      error_q  <= 1'b0;
      cpu_rd_q <= '0;
    end else begin
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      ready_q <= (state_d == S_IDLE);
      error_q <= error_d;
      if (cpu_rd_acc) cpu_rd_q <= mem[ram_addr];
    end
  end

  // -------------------------------------------------------------------------
  // Debug RAM: contents survive reset, but no write lands on a reset edge
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we && reset_n) mem[ram_addr] <= ram_wdata;
    if (jtag_rd_en) jtag_rd_q <= mem[ram_addr];
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign cpu_readdata  = cpu_rd_q;

endmodule

// File: tb/tb_nios_debug_ocimem_ctrl.sv
module tb_nios_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        debugack;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;

  nios_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .debugack                (debugack),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] jtag_exp_q[$];
  logic [31:0] cpu_exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[25:18] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // kind: 0 = take_action_a, 1 = take_no_action_a, 2 = take_action_b
  task automatic strobe(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo = '0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && !monitor_ready; i++) tick();
    check("ready_timeout", {31'd0, monitor_ready}, 32'd1);
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
    cpu_address = a;
    cpu_writedata = d;
    cpu_write = 1'b1;
    #1;
    for (int i = 0; i < 4 && cpu_waitrequest; i++) tick();
    tick();
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, input logic [31:0] e);
    cpu_exp_q.push_back(e);
    cpu_address = a;
    cpu_read = 1'b1;
    #1;
    for (int i = 0; i < 4 && cpu_waitrequest; i++) tick();
    tick();
    cpu_read = 1'b0;
    tick();
  endtask

  // Monitor: compares MonDReg on each return to ready, and cpu_readdata
  // in the cycle after each accepted CPU read.
  logic prev_ready = 1'b1;
  logic cpu_pend   = 1'b0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset_n) begin
      prev_ready = monitor_ready;
      cpu_pend   = 1'b0;
    end else begin
      if (cpu_pend) begin
        if (cpu_exp_q.size() == 0) check("cpu_unexpected_read", 32'd1, 32'd0);
        else begin
          e = cpu_exp_q.pop_front();
          check("cpu_readdata", cpu_readdata, e);
        end
      end
      cpu_pend = cpu_read && !cpu_waitrequest;
      if (monitor_ready && !prev_ready) begin
        if (jtag_exp_q.size() == 0) check("jtag_unexpected_done", 32'd1, 32'd0);
        else begin
          e = jtag_exp_q.pop_front();
          check("MonDReg_at_ready", MonDReg, e);
        end
      end
      prev_ready = monitor_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    debugack = 1'b1;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    check("rst_ready", {31'd0, monitor_ready}, 32'd1);
    check("rst_error", {31'd0, monitor_error}, 32'd0);
    check("rst_MonDReg", MonDReg, 32'd0);
    check("rst_waitreq", {31'd0, cpu_waitrequest}, 32'd0);
    check("rst_readdata", cpu_readdata, 32'd0);

    // CPU write then JTAG read with latency checks
    cpu_wr(8'h10, 32'hDEADBEEF);
    jtag_exp_q.push_back(32'hDEADBEEF);
    strobe(0, jdo_a(8'h10, 1'b1));
    check("rd_c1_ready", {31'd0, monitor_ready}, 32'd0);
    tick();
    check("rd_c2_ready", {31'd0, monitor_ready}, 32'd0);
    tick();
    check("rd_c3_ready", {31'd0, monitor_ready}, 32'd1);
    check("rd_c3_MonDReg", MonDReg, 32'hDEADBEEF);

    // Write at 0xFF, address wraps to 0, no_action read lands on 0x01
    cpu_wr(8'h00, 32'hA0A0A0A0);
    cpu_wr(8'h01, 32'h01010101);
    strobe(0, jdo_a(8'hFF, 1'b0));
    check("addr_only_ready", {31'd0, monitor_ready}, 32'd1);
    jtag_exp_q.push_back(32'h12345678);
    strobe(2, jdo_b(32'h12345678));
    check("wr_c1_ready", {31'd0, monitor_ready}, 32'd0);
    tick();
    check("wr_c2_ready", {31'd0, monitor_ready}, 32'd1);
    cpu_rd(8'hFF, 32'h12345678);
    jtag_exp_q.push_back(32'h01010101);
    strobe(1, '0);
    wait_ready();
    check("inc_wrap_read", MonDReg, 32'h01010101);

    // debugack low: strobes rejected, state untouched
    debugack = 1'b0;
    strobe(2, jdo_b(32'hBAD0BAD0));
    check("nack_b_error", {31'd0, monitor_error}, 32'd1);
    check("nack_b_ready", {31'd0, monitor_ready}, 32'd1);
    strobe(0, jdo_a(8'h10, 1'b1));
    check("nack_a_ready", {31'd0, monitor_ready}, 32'd1);
    tick();
    tick();
    check("nack_MonDReg", MonDReg, 32'h01010101);
    cpu_rd(8'h01, 32'h01010101);
    debugack = 1'b1;
    strobe(0, jdo_a(8'h20, 1'b0));
    check("ack_clears_error", {31'd0, monitor_error}, 32'd0);

    // JTAG write collides with CPU read in the WR cycle
    jtag_exp_q.push_back(32'hCAFEF00D);
    strobe(2, jdo_b(32'hCAFEF00D));
    cpu_address = 8'h20;
    cpu_read = 1'b1;
    #1;
    check("wr_cycle_waitreq", {31'd0, cpu_waitrequest}, 32'd1);
    cpu_exp_q.push_back(32'hCAFEF00D);
    tick();
    check("after_wr_waitreq", {31'd0, cpu_waitrequest}, 32'd0);
    tick();
    cpu_read = 1'b0;
    tick();

    // Strobe during RD_ADDR is dropped; the read still completes
    jtag_exp_q.push_back(32'hDEADBEEF);
    strobe(0, jdo_a(8'h10, 1'b1));
    strobe(2, jdo_b(32'h55555555));
    check("drop_error", {31'd0, monitor_error}, 32'd1);
    wait_ready();
    check("drop_MonDReg", MonDReg, 32'hDEADBEEF);
    check("drop_error_sticky", {31'd0, monitor_error}, 32'd1);
    cpu_rd(8'h10, 32'hDEADBEEF);

    // Reset during WR: write suppressed, outputs back to reset values
    strobe(0, jdo_a(8'h30, 1'b0));
    cpu_wr(8'h30, 32'h11112222);
    cpu_rd(8'h30, 32'h11112222);
    strobe(2, jdo_b(32'h99999999));
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    check("rstwr_ready", {31'd0, monitor_ready}, 32'd1);
    check("rstwr_error", {31'd0, monitor_error}, 32'd0);
    check("rstwr_MonDReg", MonDReg, 32'd0);
    check("rstwr_readdata", cpu_readdata, 32'd0);
    check("rstwr_waitreq", {31'd0, cpu_waitrequest}, 32'd0);
    cpu_rd(8'h30, 32'h11112222);

    tick();
    tick();
    check("jtag_queue_drained", jtag_exp_q.size(), 32'd0);
    check("cpu_queue_drained", cpu_exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
